counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter.sv | 78 +++++++
 tb/tb_counter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/counter.sv
// rtl/counter.sv - 2-bit up/down counter with clear, load, terminal count and carry pulse
//
// Purpose:
//   Modulo-4 up/down counter. On each rising clk edge one action is taken,
//   highest priority first: clear, parallel load, count step (direction from
//   up_dn), hold. The count bits come straight from flops. tc flags the
//   terminal value for the current direction. carry pulses for one cycle
//   after a counting edge that wrapped.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   en     in   1  count enable
//   clr    in   1  synchronous clear to 0
//   up_dn  in   1  1 = increment, 0 = decrement
//   load   in   1  synchronous parallel load of d
//   d      in   2  load value
//   Q0o    out  1  count bit 0 (registered)
//   Q1o    out  1  count bit 1 (registered)
//   tc     out  1  terminal count (combinational from count and up_dn)
//   carry  out  1  one-cycle registered wrap pulse

module counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       up_dn,
  input  logic       load,
  input  logic [1:0] d,
  output logic       Q0o,
  output logic       Q1o,
  output logic       tc,
  output logic       carry
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       carry_q;
  logic       carry_d;

  // Terminal value is 3 when counting up and 0 when counting down, so a
  // counting edge taken while tc is high is exactly a wrap.
  assign tc = up_dn ? (cnt_q == 2'd3) : (cnt_q == 2'd0);

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (load) begin
      cnt_d = d;
    end else if (en) begin
      // Only a real count step may raise carry; clear and load never do.
      carry_d = tc;
      if (up_dn) begin
        cnt_d = cnt_q + 2'd1;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign Q0o   = cnt_q[0];
  assign Q1o   = cnt_q[1];
  assign carry = carry_q;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed self-checking bench for counter
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       up_dn;
  logic       load;
  logic [1:0] d;
  logic       Q0o;
  logic       Q1o;
  logic       tc;
  logic       carry;

  int n_total;
  int n_bad;

  counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .up_dn (up_dn),
    .load  (load),
    .d     (d),
    .Q0o   (Q0o),
    .Q1o   (Q1o),
    .tc    (tc),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] eq, input logic ec, input logic etc);
    check({tag, ".q"}, {2'b00, Q1o, Q0o}, {2'b00, eq});
    check({tag, ".carry"}, {3'b000, carry}, {3'b000, ec});
    check({tag, ".tc"}, {3'b000, tc}, {3'b000, etc});
  endtask

  // Apply inputs, take one rising edge, look 1 ns later.
  task automatic step(input string tag, input logic e, input logic c, input logic u,
                      input logic l, input logic [1:0] dv,
                      input logic [1:0] eq, input logic ec, input logic etc);
    en = e; clr = c; up_dn = u; load = l; d = dv;
    @(posedge clk);
    #1;
    check_all(tag, eq, ec, etc);
  endtask

  // Assert reset mid-cycle, check outputs before the next edge, then release.
  task automatic mid_reset(input string tag);
    #4;
    rst_n = 1'b0;
    #1;
    check({tag, ".q"}, {2'b00, Q1o, Q0o}, 4'd0);
    check({tag, ".carry"}, {3'b000, carry}, 4'd0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; up_dn = 1'b1; load = 1'b0; d = 2'd0;
    #5;
    check_all("reset", 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // free-run up: 1,2,3,0,1 with carry after 3->0
    step("up1", 1, 0, 1, 0, 2'd0, 2'd1, 0, 0);
    step("up2", 1, 0, 1, 0, 2'd0, 2'd2, 0, 0);
    step("up3", 1, 0, 1, 0, 2'd0, 2'd3, 0, 1);
    step("up4", 1, 0, 1, 0, 2'd0, 2'd0, 1, 0);
    step("up5", 1, 0, 1, 0, 2'd0, 2'd1, 0, 0);

    // down from 1: 0,3,2,1,0 with carry after 0->3, tc while 0
    step("dn1", 1, 0, 0, 0, 2'd0, 2'd0, 0, 1);
    step("dn2", 1, 0, 0, 0, 2'd0, 2'd3, 1, 0);
    step("dn3", 1, 0, 0, 0, 2'd0, 2'd2, 0, 0);
    step("dn4", 1, 0, 0, 0, 2'd0, 2'd1, 0, 0);
    step("dn5", 1, 0, 0, 0, 2'd0, 2'd0, 0, 1);

    // load while tc=1 and en=1 (down at 0): no step, no carry
    step("ld_tc", 1, 0, 0, 1, 2'd0, 2'd0, 0, 1);

    // hold at 2 for five edges
    step("ld2", 0, 0, 1, 1, 2'd2, 2'd2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("hold", 0, 0, 1, 0, 2'd0, 2'd2, 0, 0);
    end

    // load wins over en; then clr wins over load while tc=1
    step("ld3", 1, 0, 1, 1, 2'd3, 2'd3, 0, 1);
    step("clr_ld", 1, 1, 1, 1, 2'd3, 2'd0, 0, 0);
    step("ld3b", 1, 0, 1, 1, 2'd3, 2'd3, 0, 1);
    step("clr_en", 1, 1, 1, 0, 2'd0, 2'd0, 0, 0);

    // async reset at count 3, then resume from 0
    step("ld3c", 0, 0, 1, 1, 2'd3, 2'd3, 0, 1);
    mid_reset("arst3");
    step("resume", 1, 0, 1, 0, 2'd0, 2'd1, 0, 0);

    // async reset while carry is high
    step("ld3d", 0, 0, 1, 1, 2'd3, 2'd3, 0, 1);
    step("wrap", 1, 0, 1, 0, 2'd0, 2'd0, 1, 0);
    mid_reset("arst_c");
    step("resume2", 1, 0, 1, 0, 2'd0, 2'd1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
